vga_timing_param: RTL and testbench
===================================

VGA_TIMING_PARAM -- requirements
Module: vga_timing_param

Interface
- REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
- REQ-002 Parameter H_FP, default 40, horizontal front porch in pixels.
- REQ-003 Parameter H_SYNC, default 128, hsync width in pixels.
- REQ-004 Parameter H_BP, default 88, horizontal back porch in pixels; line total H_TOTAL = sum of the four H parameters (1056).
- REQ-005 Parameter V_ACTIVE, default 600, visible lines per frame.
- REQ-006 Parameter V_FP, default 1, vertical front porch in lines.
- REQ-007 Parameter V_SYNC, default 4, vsync width in lines.
- REQ-008 Parameter V_BP, default 23, vertical back porch in lines; frame total V_TOTAL = sum of the four V parameters (628).
- REQ-009 Parameters H_POL and V_POL, default 1 each; the asserted level of hsync and vsync respectively.
- REQ-010 Parameter CNT_W, default 12, width of hcount and vcount; it SHALL satisfy 2^CNT_W > max(H_TOTAL, V_TOTAL).
- REQ-011 Parameter FRAME_W, default 8, width of frame_cnt.
- REQ-012 Parameter RST_VCOUNT, default 0, vcount value loaded at reset (simulation shortcut); legal range 0..V_ACTIVE-1.
- REQ-013 pclk, input, 1, pixel clock; all state SHALL update on its rising edge.
- REQ-014 rst, input, 1, synchronous, active-high reset.
- REQ-015 ce, input, 1, advance enable; when low, every output SHALL hold its value.
- REQ-016 hcount, output, CNT_W, current pixel index, 0..H_TOTAL-1.
- REQ-017 vcount, output, CNT_W, current line index, 0..V_TOTAL-1.
- REQ-018 hsync, output, 1; vsync, output, 1: sync outputs driven at the polarity set by H_POL / V_POL.
- REQ-019 hblnk, output, 1; vblnk, output, 1: blanking flags, active-high.
- REQ-020 de, output, 1, data enable, high in the visible region.
- REQ-021 line_start, output, 1; frame_start, output, 1: single-cycle strobes.
- REQ-022 frame_cnt, output, FRAME_W, count of completed frames.

Function
- REQ-023 All outputs SHALL be registered, and every flag SHALL be coherent with hcount/vcount on the same cycle (no one-cycle skew).
- REQ-024 On a cycle where ce=1: if hcount = H_TOTAL-1, hcount SHALL become 0; otherwise hcount SHALL increment by 1.
- REQ-025 On a cycle where ce=1 and hcount = H_TOTAL-1: if vcount = V_TOTAL-1, vcount SHALL become 0; otherwise vcount SHALL increment by 1. vcount SHALL not change on any other cycle.
- REQ-026 hblnk SHALL be 1 exactly when hcount >= H_ACTIVE.
- REQ-027 vblnk SHALL be 1 exactly when vcount >= V_ACTIVE.
- REQ-028 hsync SHALL equal H_POL exactly when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, and !H_POL otherwise.
- REQ-029 vsync SHALL equal V_POL exactly when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, and !V_POL otherwise; vsync transitions SHALL occur only with hcount = 0.
- REQ-030 de SHALL equal !hblnk && !vblnk.
- REQ-031 line_start SHALL be 1 for one cycle each time hcount enters 0 through the wrap in REQ-024.
- REQ-032 frame_start SHALL be 1 for one cycle each time (hcount, vcount) enters (0,0) through the wrap in REQ-025.
- REQ-033 With ce=0, line_start and frame_start SHALL hold their values; a strobe SHALL therefore persist while ce stays low.
- REQ-034 frame_cnt SHALL increment modulo 2^FRAME_W on the same edge on which frame_start is set.

Reset
- REQ-035 When rst=1 at a pclk edge, rst SHALL take priority over ce and the block SHALL load: hcount=0, vcount=RST_VCOUNT, hblnk=0, vblnk=0, hsync=!H_POL, vsync=!V_POL, de=1, line_start=0, frame_start=0, frame_cnt=0.
- REQ-036 Reset asserted at any point in a line or frame SHALL abort it; counting SHALL resume from the reset position on the first edge with rst=0 and ce=1.

Verification
- REQ-037 Defaults, ce=1, reset released: hcount 799->800 raises hblnk and drops de; hsync is high for hcount 840..967; hcount 1055->0 produces a line_start pulse.
- REQ-038 RST_VCOUNT=592: vblnk rises when vcount=600 and hcount=0; vsync is high for vcount 601..604; vcount 627->0 with hcount 1055->0 produces frame_start=1 and frame_cnt=1.
- REQ-039 ce pulled low for 5 cycles at hcount=1055: all outputs frozen; the next ce=1 edge gives hcount=0 and line_start=1.
- REQ-040 H_POL=0, V_POL=0: hsync and vsync are idle-high, low only inside their sync windows, and 1 (idle) directly after reset.
- REQ-041 rst asserted at hcount=500, vcount=300: the next edge gives hcount=0, vcount=RST_VCOUNT, frame_cnt=0, and all strobes 0.
- REQ-042 FRAME_W=2 over 5 frames: frame_cnt reads 1,2,3,0,1, and there is exactly one frame_start per frame.

Source files
------------

// File: rtl/vga_timing_param.sv
// Parameterised VGA raster timing generator: pixel/line counters with registered,
// count-coherent sync, blanking, data-enable and line/frame strobes.
module vga_timing_param #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int H_POL      = 1,
  parameter int V_POL      = 1,
  parameter int CNT_W      = 12,
  parameter int FRAME_W    = 8,
  parameter int RST_VCOUNT = 0
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               ce,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_RST     = CNT_W'(RST_VCOUNT);
  localparam logic             H_ON      = (H_POL != 0);
  localparam logic             V_ON      = (V_POL != 0);

  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;
  logic               de_q, de_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  logic               h_wrap, v_wrap;
  logic [CNT_W-1:0]   hcount_nx, vcount_nx;

  // Flags are decoded from the next counter values so they land on the same
  // edge as the counters they describe.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblnk_d       = hblnk_q;
    vblnk_d       = vblnk_q;
    de_d          = de_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;

    h_wrap    = (hcount_q == H_LAST);
    v_wrap    = (vcount_q == V_LAST);
    hcount_nx = h_wrap ? '0 : hcount_q + CNT_W'(1);
    vcount_nx = vcount_q;
    if (h_wrap) begin
      vcount_nx = v_wrap ? '0 : vcount_q + CNT_W'(1);
    end

    if (ce) begin
      hcount_d      = hcount_nx;
      vcount_d      = vcount_nx;
      hblnk_d       = (hcount_nx >= H_ACT_END);
      vblnk_d       = (vcount_nx >= V_ACT_END);
      de_d          = (hcount_nx < H_ACT_END) && (vcount_nx < V_ACT_END);
      hsync_d       = ((hcount_nx >= HS_BEGIN) && (hcount_nx < HS_END)) ? H_ON : ~H_ON;
      vsync_d       = ((vcount_nx >= VS_BEGIN) && (vcount_nx < VS_END)) ? V_ON : ~V_ON;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= V_RST;
      hsync_q       <= ~H_ON;
      vsync_q       <= ~V_ON;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Scoreboard bench for vga_timing_param: a default-timing instance started near the
// bottom of the frame, and a tiny inverted-polarity instance with a 2-bit frame counter.
module tb_vga_timing_param;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic [7:0]  fc;
    logic        hs, vs, hb, vb, de, ls, fs;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, fw, rv;
  } tp_t;

  logic pclk;
  logic rst_a, ce_a, rst_b, ce_b;

  logic [11:0] hc_a, vc_a;
  logic [7:0]  fc_a;
  logic        hs_a, vs_a, hb_a, vb_a, de_a, ls_a, fs_a;
  logic [4:0]  hc_b, vc_b;
  logic [1:0]  fc_b;
  logic        hs_b, vs_b, hb_b, vb_b, de_b, ls_b, fs_b;

  vga_timing_param #(.RST_VCOUNT(592)) dut_a (
    .pclk(pclk), .rst(rst_a), .ce(ce_a), .hcount(hc_a), .vcount(vc_a),
    .hsync(hs_a), .vsync(vs_a), .hblnk(hb_a), .vblnk(vb_a), .de(de_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a));

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(0), .V_POL(0), .CNT_W(5), .FRAME_W(2), .RST_VCOUNT(0)
  ) dut_b (
    .pclk(pclk), .rst(rst_b), .ce(ce_b), .hcount(hc_b), .vcount(vc_b),
    .hsync(hs_b), .vsync(vs_b), .hblnk(hb_b), .vblnk(vb_b), .de(de_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b));

  obs_t act_a, act_b;
  assign act_a = {hc_a, vc_a, fc_a, hs_a, vs_a, hb_a, vb_a, de_a, ls_a, fs_a};
  assign act_b = {7'd0, hc_b, 7'd0, vc_b, 6'd0, fc_b, hs_b, vs_b, hb_b, vb_b, de_b, ls_b, fs_b};

  int   n_cmp = 0;
  int   n_bad = 0;
  tp_t  pa, pb;
  obs_t ma, mb;
  obs_t qa[$];
  obs_t qb[$];

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model: position on the raster plus flags derived from window arithmetic.
  function automatic obs_t with_flags(obs_t s, tp_t p);
    int h = int'(s.h);
    int v = int'(s.v);
    obs_t n = s;
    n.hb = (h >= p.ha);
    n.vb = (v >= p.va);
    n.hs = (h >= p.ha + p.hf && h < p.ha + p.hf + p.hs) ? (p.hpol != 0) : (p.hpol == 0);
    n.vs = (v >= p.va + p.vf && v < p.va + p.vf + p.vs) ? (p.vpol != 0) : (p.vpol == 0);
    n.de = !n.hb && !n.vb;
    return n;
  endfunction

  function automatic obs_t step(obs_t s, tp_t p, logic ce, logic rst);
    int ht = p.ha + p.hf + p.hs + p.hb;
    int vt = p.va + p.vf + p.vs + p.vb;
    obs_t n = s;
    if (rst) begin
      n.h = 12'd0; n.v = 12'(p.rv); n.fc = 8'd0; n.ls = 1'b0; n.fs = 1'b0;
      n = with_flags(n, p);
    end else if (ce) begin
      n.ls = (int'(s.h) == ht - 1);
      n.fs = n.ls && (int'(s.v) == vt - 1);
      n.h  = n.ls ? 12'd0 : 12'(int'(s.h) + 1);
      if (n.ls) n.v = n.fs ? 12'd0 : 12'(int'(s.v) + 1);
      if (n.fs) n.fc = 8'((int'(s.fc) + 1) % (1 << p.fw));
      n = with_flags(n, p);
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual h=%0d v=%0d fc=%0d hs/vs/hb/vb/de/ls/fs=%b%b%b%b%b%b%b required h=%0d v=%0d fc=%0d hs/vs/hb/vb/de/ls/fs=%b%b%b%b%b%b%b",
               name, $time, act.h, act.v, act.fc, act.hs, act.vs, act.hb, act.vb, act.de, act.ls, act.fs,
               exp.h, exp.v, exp.fc, exp.hs, exp.vs, exp.hb, exp.vb, exp.de, exp.ls, exp.fs);
    end
  endtask

  // Monitor: each edge consumes the expectation queued for it.
  always begin
    @(posedge pclk);
    #1;
    if (qa.size() > 0) chk_obs("sb_a", act_a, qa.pop_front());
    if (qb.size() > 0) chk_obs("sb_b", act_b, qb.pop_front());
  end

  task automatic tick_a(input logic c, input logic r);
    @(negedge pclk);
    ce_a = c; rst_a = r;
    ma = step(ma, pa, c, r);
    qa.push_back(ma);
  endtask

  task automatic tick_b(input logic c, input logic r);
    @(negedge pclk);
    ce_b = c; rst_b = r;
    mb = step(mb, pb, c, r);
    qb.push_back(mb);
  endtask

  task automatic settle();
    @(posedge pclk);
    #1;
  endtask

  task automatic run_a();
    bit seen600 = 0;
    tick_a(1'b0, 1'b1);
    tick_a(1'b1, 1'b1);
    settle();
    chk("a_rst_vcount", 32'(vc_a), 592);
    chk("a_rst_de", 32'(de_a), 1);
    chk("a_rst_hsync", 32'(hs_a), 0);
    repeat (799) tick_a(1'b1, 1'b0);
    settle();
    chk("a_h799_hblnk", 32'(hb_a), 0);
    tick_a(1'b1, 1'b0);
    settle();
    chk("a_h800_hcount", 32'(hc_a), 800);
    chk("a_h800_hblnk", 32'(hb_a), 1);
    chk("a_h800_de", 32'(de_a), 0);
    repeat (40) tick_a(1'b1, 1'b0);
    settle();
    chk("a_h840_hsync", 32'(hs_a), 1);
    repeat (127) tick_a(1'b1, 1'b0);
    settle();
    chk("a_h967_hsync", 32'(hs_a), 1);
    tick_a(1'b1, 1'b0);
    settle();
    chk("a_h968_hsync", 32'(hs_a), 0);
    repeat (87) tick_a(1'b1, 1'b0);
    repeat (5) tick_a(1'b0, 1'b0);
    settle();
    chk("a_frozen_hcount", 32'(hc_a), 1055);
    chk("a_frozen_line_start", 32'(ls_a), 0);
    tick_a(1'b1, 1'b0);
    settle();
    chk("a_wrap_hcount", 32'(hc_a), 0);
    chk("a_wrap_line_start", 32'(ls_a), 1);
    chk("a_wrap_vcount", 32'(vc_a), 593);
    for (int i = 0; i < 2000 && ma.h != 12'd500; i++) tick_a(1'b1, 1'b0);
    tick_a(1'b1, 1'b1);
    settle();
    chk("a_midrst_hcount", 32'(hc_a), 0);
    chk("a_midrst_vcount", 32'(vc_a), 592);
    chk("a_midrst_frame_cnt", 32'(fc_a), 0);
    chk("a_midrst_strobes", {30'd0, ls_a, fs_a}, 0);
    for (int i = 0; i < 60000 && !ma.fs; i++) begin
      tick_a(1'($urandom_range(0, 9) != 0), 1'b0);
      if (!seen600 && ma.v == 12'd600 && ma.h == 12'd0) begin
        seen600 = 1;
        settle();
        chk("a_v600_vblnk", 32'(vb_a), 1);
      end
    end
    if (!ma.fs) begin
      n_cmp++; n_bad++;
      $display("FAIL a_frame_timeout: actual=no frame wrap required=frame wrap within budget");
    end else begin
      settle();
      chk("a_frame_start", 32'(fs_a), 1);
      chk("a_frame_cnt", 32'(fc_a), 1);
      chk("a_frame_vcount", 32'(vc_a), 0);
    end
    repeat (2000) tick_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    tick_a(1'b0, 1'b0);
  endtask

  task automatic run_b();
    int got[$];
    int exp_fc[5] = '{1, 2, 3, 0, 1};
    tick_b(1'b0, 1'b1);
    tick_b(1'b0, 1'b1);
    settle();
    chk("b_rst_hsync_idle", 32'(hs_b), 1);
    chk("b_rst_vsync_idle", 32'(vs_b), 1);
    repeat (760) begin
      tick_b(1'b1, 1'b0);
      settle();
      if (fs_b === 1'b1) got.push_back(int'(fc_b));
    end
    chk("b_frame_starts", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("b_frame_cnt%0d", i), 32'(got[i]), 32'(exp_fc[i]));
    repeat (3000) tick_b(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 49) == 0));
    tick_b(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pa = '{ha: 800, hf: 40, hs: 128, hb: 88, va: 600, vf: 1, vs: 4, vb: 23,
           hpol: 1, vpol: 1, fw: 8, rv: 592};
    pb = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 5, vf: 1, vs: 2, vb: 2,
           hpol: 0, vpol: 0, fw: 2, rv: 0};
    rst_a = 1'b1; ce_a = 1'b0;
    rst_b = 1'b1; ce_b = 1'b0;
    fork
      run_a();
      run_b();
    join
    repeat (3) @(posedge pclk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
